// File: rtl/div_mul_pkg.sv
// Shared definitions for the MUL/DIV execution slot: kgp carry encodings,
// divider FSM states and the prefix-combine cell.
package div_mul_pkg;

    localparam int DIV_WIDTH = 64;

    localparam logic [1:0] KGP_KILL = 2'b00;
    localparam logic [1:0] KGP_PROP = 2'b01;
    localparam logic [1:0] KGP_GEN  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FIX,
        ZERO,
        DONE
    } div_state_e;

    // Parallel-prefix cell: a propagating upper group passes the lower group's status.
    function automatic logic [1:0] kgp_combine(input logic [1:0] hi, input logic [1:0] lo);
        return (hi == KGP_PROP) ? lo : hi;
    endfunction

endpackage

// File: rtl/sub_65_kgp.sv
// Combinational W-bit subtractor a - b, evaluated as a + ~b + 1 through a
// Kogge-Stone kgp prefix network; borrow is the inverted carry out.
module sub_65_kgp
    import div_mul_pkg::*;
#(
    parameter int W = DIV_WIDTH + 1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    // Element 0 of the prefix vector is the constant carry-in, so NE = W + 1.
    localparam int NE = W + 1;
    localparam int LV = $clog2(NE);

    logic [W-1:0]         bn;
    logic [W-1:0]         prop;
    logic [NE-1:0][1:0]   kgp_init;
    logic [NE-1:0][1:0]   pre_d;
    logic [NE-1:0][1:0]   cur_d;
    logic [NE-1:0][1:0]   nxt_d;
    logic [NE-1:0]        carry;

    assign bn          = ~b_i;
    assign prop        = a_i ^ bn;
    assign kgp_init[0] = KGP_GEN;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            assign kgp_init[gi+1] = (a_i[gi] & bn[gi]) ? KGP_GEN :
                                    (prop[gi] ? KGP_PROP : KGP_KILL);
        end
        for (gi = 0; gi < NE; gi++) begin : g_carry
            assign carry[gi] = (pre_d[gi] == KGP_GEN);
        end
        for (gi = 0; gi < W; gi++) begin : g_diff
            assign diff_o[gi] = prop[gi] ^ carry[gi];
        end
    endgenerate

    always_comb begin
        cur_d = kgp_init;
        nxt_d = kgp_init;
        for (int l = 0; l < LV; l++) begin
            nxt_d = cur_d;
            for (int j = 0; j < NE; j++) begin
                if (j >= (1 << l)) begin
                    nxt_d[j] = kgp_combine(cur_d[j], cur_d[j - (1 << l)]);
                end
            end
            cur_d = nxt_d;
        end
        pre_d = cur_d;
    end

    assign borrow_o = ~carry[W];

endmodule

// File: rtl/div_64_seq.sv
// Iterative restoring divider, one quotient bit per cycle, signed or unsigned,
// with valid/ready handshakes and a single operation in flight.
module div_64_seq
    import div_mul_pkg::*;
#(
    parameter int WIDTH     = DIV_WIDTH,
    parameter bit ZERO_FAST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] dvd_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             zero_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;

    logic [WIDTH:0]   r_shift_d;
    logic [WIDTH:0]   trial_d;
    logic             borrow_d;
    logic             a_neg_d;
    logic             b_neg_d;
    logic [WIDTH-1:0] q_fix_d;
    logic [WIDTH-1:0] r_fix_d;

    // R never exceeds the divisor, so its top bit stays clear; folding it in keeps all of R live.
    assign r_shift_d = {r_q[WIDTH-1:0], n_q[WIDTH-1]} | {r_q[WIDTH], {WIDTH{1'b0}}};

    sub_65_kgp #(.W(WIDTH + 1)) u_sub (
        .a_i      (r_shift_d),
        .b_i      ({1'b0, d_q}),
        .diff_o   (trial_d),
        .borrow_o (borrow_d)
    );

    assign a_neg_d = is_signed & dividend[WIDTH-1];
    assign b_neg_d = is_signed & divisor[WIDTH-1];
    assign q_fix_d = neg_quo_q ? -q_q : q_q;
    assign r_fix_d = neg_rem_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            n_q         <= '0;
            d_q         <= '0;
            dvd_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        n_q       <= a_neg_d ? -dividend : dividend;
                        d_q       <= b_neg_d ? -divisor : divisor;
                        dvd_q     <= dividend;
                        neg_quo_q <= a_neg_d ^ b_neg_d;
                        neg_rem_q <= a_neg_d;
                        zero_q    <= (divisor == '0);
                        r_q       <= '0;
                        q_q       <= '0;
                        cnt_q     <= '0;
                        state_q   <= ((divisor == '0) && ZERO_FAST) ? ZERO : CALC;
                    end
                end
                CALC: begin
                    r_q   <= borrow_d ? r_shift_d : trial_d;
                    q_q   <= {q_q[WIDTH-2:0], ~borrow_d};
                    n_q   <= n_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    // A zero divisor reports the same result whichever path computed it.
                    quo_q       <= zero_q ? '1 : q_fix_d;
                    rem_q       <= zero_q ? dvd_q : r_fix_d;
                    dbz_q       <= zero_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                ZERO: begin
                    quo_q       <= '1;
                    rem_q       <= dvd_q;
                    dbz_q       <= 1'b1;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
